data_mem_ctrl: RTL
==================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 64, giving the number of 32-bit words in the data array.
REQ-002 The block SHALL have parameter WAIT_STATES, default 1, giving the extra access cycles (0..15).
REQ-003 The block SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 The block SHALL have port reset  input  1  reset; synchronous, active-high.
REQ-005 The block SHALL have port req_valid  input  1  core presents a load/store request.
REQ-006 The block SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 The block SHALL have port req_funct3  input  3  RV32I width/sign code.
REQ-008 The block SHALL have port req_addr  input  32  byte address.
REQ-009 The block SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-010 The block SHALL have port req_ready  output  1  request may be accepted this cycle.
REQ-011 The block SHALL have port rsp_valid  output  1  one-cycle completion strobe.
REQ-012 The block SHALL have port rsp_rdata  output  32  extended load data.
REQ-013 The block SHALL have port rsp_err  output  1  misaligned, out-of-range or illegal access.
REQ-014 The block SHALL have port mmio_out  output  32  memory-mapped output register.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-016 A request SHALL be accepted on an edge where req_valid && req_ready; req_we, req_funct3, req_addr and req_wdata are latched on that edge.
REQ-017 After acceptance, the FSM SHALL go to WAIT if WAIT_STATES > 0, else to RESP; WAIT counts WAIT_STATES cycles, then goes to RESP.
REQ-018 rsp_valid SHALL be high for exactly the single RESP cycle; RESP -> IDLE unconditionally; an accepted request completes with rsp_valid in cycle N+1+WAIT_STATES.
REQ-019 req_valid outside IDLE SHALL be ignored, and no back-to-back acceptance SHALL occur in the RESP cycle.
REQ-020 Loads SHALL decode funct3 as: 000 LB sign-extend, 001 LH sign-extend, 010 LW, 100 LBU zero-extend, 101 LHU zero-extend; the byte/half is selected by addr[1:0].
REQ-021 Stores SHALL decode funct3 as: 000 SB, 001 SH, 010 SW; byte enables are derived from addr[1:0], and unselected bytes are preserved.
REQ-022 A store SHALL write the array on the edge entering RESP.
REQ-023 A load SHALL capture rsp_rdata on the edge entering RESP and hold it until the next response.
REQ-024 rsp_err SHALL be set in RESP for: halfword with addr[0]=1; word with addr[1:0]!=0; addr[31:2] >= DEPTH_WORDS (excluding the MMIO address when enabled); load funct3 in {011,110,111}; store funct3 not in {000,001,010}.
REQ-025 On rsp_err, no array/MMIO write SHALL occur and rsp_rdata SHALL be 0.
REQ-026 rsp_rdata SHALL be 0 for completed stores.

Reset
REQ-027 When reset is high on an edge: FSM -> IDLE, wait counter = 0, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, mmio_out = 0.
REQ-028 Reset SHALL take priority over every other event; a request in WAIT is aborted without writing, and array contents are not cleared.

Configuration
REQ-029 With macro DMEM_MMIO_EN defined: address 32'hFFFF_FFF0 SHALL be an MMIO register; SW loads mmio_out, LW returns mmio_out, and any byte/half access there sets rsp_err.
REQ-030 Without DMEM_MMIO_EN: mmio_out SHALL be tied to 0, and 32'hFFFF_FFF0 SHALL be out of range (rsp_err).

Verification
REQ-031 Reset, then SW addr 0x8 data 0xDEADBEEF, then LW 0x8 -> rsp_rdata 0xDEADBEEF, rsp_err 0, with rsp_valid 2 cycles after each accept (WAIT_STATES=1).
REQ-032 With word 0x8 = 0xDEADBEEF, SB 0x9 data 0x55 -> LW 0x8 returns 0xDEAD55EF; LB 0xB returns 0xFFFFFFDE; LBU 0xB returns 0x000000DE; LH 0xA returns 0xFFFFDEAD.
REQ-033 LW 0x6, SH 0x3, and LW 0x100 (DEPTH_WORDS=64) -> rsp_err 1, rsp_rdata 0; word 0x4 is unchanged afterwards.
REQ-034 Assert reset while in WAIT during SW 0x10 data 0x12345678 -> no rsp_valid, req_ready 1 next cycle, and LW 0x10 returns the prior value.
REQ-035 DMEM_MMIO_EN defined: SW 0xFFFFFFF0 data 0xA5 -> mmio_out 0x000000A5 in the RESP cycle. Undefined: rsp_err 1, mmio_out 0.
REQ-036 Hold req_valid high continuously -> acceptances are spaced exactly 2+WAIT_STATES cycles apart, and req_ready is never high in WAIT or RESP.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: RV32I load/store unit in front of a word array with
// configurable wait states. Define DMEM_MMIO_EN to map an output register at 32'hFFFF_FFF0.
module data_mem_ctrl #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mmio_out
);

  localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
  localparam logic [31:0] MMIO_ADDR = 32'hFFFF_FFF0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        lat_we;
  logic [2:0]  lat_funct3;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] mmio_q;
  logic [31:0] mem [DEPTH_WORDS];

  // Request being serviced: the live inputs when a zero-wait access goes
  // straight from IDLE to RESP, otherwise the fields latched at acceptance.
  logic        cur_we;
  logic [2:0]  cur_funct3;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;

  logic             accept;
  logic             enter_resp;
  logic [IDX_W-1:0] word_idx;
  logic             is_mmio;
  logic             in_range;
  logic             misalign;
  logic             funct3_ok;
  logic             target_ok;
  logic             acc_err;
  logic [31:0]      old_word;
  logic [31:0]      shifted;
  logic [31:0]      load_data;
  logic [3:0]       byte_en;
  logic [31:0]      wdata_rep;
  logic [31:0]      merged;
  logic             do_write;

  assign accept     = req_valid && req_ready;
  assign enter_resp = (accept && (WAIT_STATES == 0)) || ((state == WAIT) && (wait_cnt == 4'd0));

`ifdef DMEM_MMIO_EN
  assign is_mmio = (cur_addr == MMIO_ADDR);
`else
  assign is_mmio = 1'b0;
  assign mmio_q  = '0;
`endif
  assign mmio_out = mmio_q;

  // NOTE: every signal written in this block gets a default first, so no
  // path through the case statements can leave it holding and infer a latch.
  always_comb begin
    cur_we     = lat_we;
    cur_funct3 = lat_funct3;
    cur_addr   = lat_addr;
    cur_wdata  = lat_wdata;
    if (state == IDLE) begin
      cur_we     = req_we;
      cur_funct3 = req_funct3;
      cur_addr   = req_addr;
      cur_wdata  = req_wdata;
    end

    word_idx  = cur_addr[IDX_W+1:2];
    in_range  = cur_addr[31:2] < DEPTH_LIM;
    misalign  = ((cur_funct3[1:0] == 2'b01) && cur_addr[0]) ||
                ((cur_funct3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00));
    funct3_ok = cur_we ? (cur_funct3 inside {3'b000, 3'b001, 3'b010})
                       : (cur_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    // The MMIO register only supports full-word access.
    target_ok = is_mmio ? (cur_funct3 == 3'b010) : in_range;
    acc_err   = !funct3_ok || misalign || !target_ok;

    old_word  = is_mmio ? mmio_q : mem[word_idx];
    shifted   = old_word >> {cur_addr[1:0], 3'b000};

    load_data = '0;
    case (cur_funct3)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  load_data = old_word;
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b101:  load_data = {16'd0, shifted[15:0]};
      default: load_data = '0;
    endcase

    byte_en   = 4'b1111;
    wdata_rep = cur_wdata;
    case (cur_funct3[1:0])
      2'b00: begin
        byte_en   = 4'b0001 << cur_addr[1:0];
        wdata_rep = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        byte_en   = cur_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{cur_wdata[15:0]}};
      end
      default: begin
        byte_en   = 4'b1111;
        wdata_rep = cur_wdata;
      end
    endcase

    for (int i = 0; i < 4; i++) begin
      merged[i*8 +: 8] = byte_en[i] ? wdata_rep[i*8 +: 8] : old_word[i*8 +: 8];
    end

    do_write = enter_resp && cur_we && !acc_err && !reset;
  end

  // NOTE: the data array has no reset; its contents survive reset and only
  // the control path is reinitialised.
  always_ff @(posedge clk) begin
    if (do_write && !is_mmio) begin
      mem[word_idx] <= merged;
    end
  end

  // NOTE: all state and registered outputs update with non-blocking
  // assignments so every read in this block sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
`ifdef DMEM_MMIO_EN
      mmio_q    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat_we     <= req_we;
            lat_funct3 <= req_funct3;
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata;
            req_ready  <= 1'b0;
            if (WAIT_STATES == 0) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end else begin
              state    <= WAIT;
              wait_cnt <= WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase

      if (enter_resp) begin
        rsp_err   <= acc_err;
        rsp_rdata <= (acc_err || cur_we) ? 32'd0 : load_data;
`ifdef DMEM_MMIO_EN
        if (cur_we && is_mmio && !acc_err) begin
          mmio_q <= merged;
        end
`endif
      end
    end
  end

endmodule
